mpmc10_cache: RTL and testbench
===============================

MPMC10_CACHE -- requirements
Module: mpmc10_cache

Interface
REQ-001 SHALL have parameter NPORT, default 8: number of independent read ports (1..8).
REQ-002 SHALL have parameter NWAY, default 4: associativity (power of two, 1..8).
REQ-003 SHALL have parameter NLINE, default 128: lines per way (power of two); IDXW = log2(NLINE).
REQ-004 SHALL have parameter LINEW, default 256: line data bits; OFSW = log2(LINEW/8); TAGW = 32-IDXW-OFSW.
REQ-005 SHALL have a single clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-006 SHALL have port `clk  in  1`: sole clock for all ports.
REQ-007 SHALL have port `rst  in  1`: asynchronous, active-high reset.
REQ-008 SHALL have port `rreq  in  NPORT`: per-port read request.
REQ-009 SHALL have port `radr  in  NPORT x 32`: per-port byte address.
REQ-010 SHALL have port `rvalid  out  NPORT`: per-port result strobe.
REQ-011 SHALL have port `hit  out  NPORT`: lookup hit, qualified by rvalid.
REQ-012 SHALL have port `hway  out  NPORT x log2(NWAY)`: hitting way.
REQ-013 SHALL have port `rdat  out  NPORT x LINEW`: hitting line data, zero on miss.
REQ-014 SHALL have port `fill  in  1`: install the line at wadr.
REQ-015 SHALL have port `upd  in  1`: byte-enable update on a write hit.
REQ-016 SHALL have port `wadr  in  32`: write/invalidate address.
REQ-017 SHALL have port `wbe  in  LINEW/8`: byte enables, used by upd only.
REQ-018 SHALL have port `wdat  in  LINEW`: write data.
REQ-019 SHALL have port `inv  in  1`: invalidate the line at wadr in every matching way.
REQ-020 SHALL have port `flush  in  1`: invalidate the whole cache.
REQ-021 SHALL have port `busy  out  1`: flush in progress.
REQ-022 SHALL have port `fway  out  log2(NWAY)`: way chosen by the last fill.

Function
REQ-023 SHALL give every read port a fixed 2-cycle latency: request in cycle N, then rvalid, hit, hway and rdat valid in cycle N+2 for exactly one cycle.
REQ-024 SHALL accept a new request on any port every cycle (fully pipelined), with ports independent and never blocking each other.
REQ-025 SHALL compute hit as tag(radr[31:IDXW+OFSW]) equal to stored tag AND valid bit set, for some way.
REQ-026 SHALL keep ways exclusive: a fill to an address already present SHALL overwrite the hitting way, not allocate a second one.
REQ-027 SHALL select the fill victim as follows: the first invalid way (lowest index) at the target index; otherwise the way given by a per-index round-robin pointer (NLINE x log2(NWAY) flops), which SHALL advance by 1 mod NWAY after each victimising fill.
REQ-028 SHALL have a fill write the tag and the full line, set the valid bit, and update fway, all effective for reads whose lookup cycle starts in the cycle after the fill.
REQ-029 SHALL have upd perform a byte-masked write of wdat into the hitting way only; on an upd miss, no state SHALL change.
REQ-030 SHALL have inv clear the valid bit of the matching way at the wadr index; an inv miss SHALL be a no-op.
REQ-031 SHALL prioritise same-cycle write-side operations as fill > upd > inv; the lower-priority operations SHALL be dropped.
REQ-032 SHALL treat a same-cycle read and write to the same line as read-first: the read returns the pre-write contents and the pre-write hit state.
REQ-033 SHALL implement the flush state machine IDLE -> FLUSH when flush is sampled in IDLE.
REQ-034 SHALL have FLUSH clear the valid bits of every way at one index per cycle, counting idx 0..NLINE-1, and return to IDLE after idx NLINE-1, i.e. after exactly NLINE cycles.
REQ-035 SHALL hold busy=1 throughout FLUSH.
REQ-036 SHALL, while busy, ignore fill, upd and inv.
REQ-037 SHALL, while busy, force every read to complete with hit=0 and rdat=0 while still producing rvalid.
REQ-038 SHALL ignore flush asserted while already in FLUSH; the index counter SHALL not restart.
REQ-039 SHALL let reads issued in the cycle after FLUSH exits observe an empty cache.

Reset
REQ-040 SHALL, on rst asserted asynchronously, clear all valid bits and round-robin pointers, and force state=IDLE, idx=0, busy=0, fway=0, rvalid=0, hit=0, hway=0, rdat=0.
REQ-041 SHALL, on rst mid-flush, abort the flush immediately; the cache SHALL be empty after rst deasserts.
REQ-042 SHALL leave tag/data RAM contents unreset; only valid bits SHALL gate hits.

Structure
REQ-043 SHALL place the parameter defaults, the mpmc10_cache_line_t typedef (tag + data) and the flush-state enum in mpmc10_pkg.
REQ-044 SHALL factor one way-lookup sub-module, mpmc10_cache_way (one way: tag/data RAM with NPORT read ports and one write port, plus registered tag compare), instantiated NWAY times.
REQ-045 SHALL hold valid bits and round-robin pointers in flops within the top level.

Verification
REQ-046 SHALL cover: fill 0x0000_1000 with data A, then read port 3 at 0x0000_1000 -> rvalid at +2, hit=1, hway=0, rdat=A; read 0x0000_2000 at the same index -> hit=0, rdat=0.
REQ-047 SHALL cover: five fills at the same index, distinct tags, NWAY=4 -> ways 0,1,2,3 used, then the 5th fill evicts way 0; a read of the first tag -> miss.
REQ-048 SHALL cover: upd with wbe=0x0000_000F on a hit line -> only bytes 0-3 change; upd to an absent address -> no change on any port read.
REQ-049 SHALL cover: all 8 ports reading distinct filled lines every cycle for 100 cycles -> 100 rvalid per port, all hit, correct data.
REQ-050 SHALL cover: flush, then fill on the next cycle -> busy for exactly 128 cycles, fill ignored, all reads miss afterwards; rst at flush cycle 40 -> busy=0 and empty cache.
REQ-051 SHALL cover: fill and read of the same address in the same cycle -> miss (read-first); the same read one cycle later -> hit.

Source files
------------

// File: rtl/mpmc10_pkg.sv
// Shared defaults, line record and flush-state encoding for the mpmc10 line cache.
package mpmc10_pkg;

  localparam int unsigned NPORT_DEF = 8;
  localparam int unsigned NWAY_DEF  = 4;
  localparam int unsigned NLINE_DEF = 128;
  localparam int unsigned LINEW_DEF = 256;
  localparam int unsigned IDXW_DEF  = $clog2(NLINE_DEF);
  localparam int unsigned OFSW_DEF  = $clog2(LINEW_DEF / 8);
  localparam int unsigned TAGW_DEF  = 32 - IDXW_DEF - OFSW_DEF;

  typedef struct packed {
    logic [TAGW_DEF-1:0]  tag;
    logic [LINEW_DEF-1:0] data;
  } mpmc10_cache_line_t;

  typedef enum logic {StIdle, StFlush} flush_state_e;

endpackage

// File: rtl/mpmc10_cache_way.sv
// One cache way: tag/data RAM with NPORT registered lookups and a single byte-masked write port.
module mpmc10_cache_way #(
  parameter int unsigned NPORT = 8,
  parameter int unsigned NLINE = 128,
  parameter int unsigned LINEW = 256,
  parameter int unsigned IDXW  = 7,
  parameter int unsigned TAGW  = 20
) (
  input  logic                        clk_i,
  input  logic [NPORT-1:0][IDXW-1:0]  ridx_i,
  input  logic [NPORT-1:0][TAGW-1:0]  rtag_i,
  output logic [NPORT-1:0]            rmatch_o,
  output logic [NPORT-1:0][LINEW-1:0] rdat_o,
  input  logic [IDXW-1:0]             widx_i,
  input  logic [TAGW-1:0]             wtag_i,
  input  logic                        we_i,
  input  logic [LINEW/8-1:0]          wbe_i,
  input  logic [LINEW-1:0]            wdat_i,
  output logic                        wmatch_o
);

  logic [TAGW-1:0]            tag_q [NLINE];
  logic [LINEW-1:0]           dat_q [NLINE];
  logic [NPORT-1:0]           rmatch_q;
  logic [NPORT-1:0][LINEW-1:0] rdat_q;

  // RAM is deliberately unreset; the valid bits in the top level gate every hit.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[widx_i] <= wtag_i;
      for (int b = 0; b < LINEW / 8; b++) begin
        if (wbe_i[b]) dat_q[widx_i][b*8 +: 8] <= wdat_i[b*8 +: 8];
      end
    end
    for (int p = 0; p < NPORT; p++) begin
      rmatch_q[p] <= (tag_q[ridx_i[p]] == rtag_i[p]);
      rdat_q[p]   <= dat_q[ridx_i[p]];
    end
  end

  assign rmatch_o = rmatch_q;
  assign rdat_o   = rdat_q;
  assign wmatch_o = (tag_q[widx_i] == wtag_i);

endmodule

// File: rtl/mpmc10_cache.sv
// Multi-port set-associative line cache: 2-cycle read ports, fill/upd/inv write side, timed flush.
module mpmc10_cache
  import mpmc10_pkg::*;
#(
  parameter int unsigned NPORT = NPORT_DEF,
  parameter int unsigned NWAY  = NWAY_DEF,
  parameter int unsigned NLINE = NLINE_DEF,
  parameter int unsigned LINEW = LINEW_DEF,
  localparam int unsigned WAYW = (NWAY > 1) ? $clog2(NWAY) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORT-1:0]            rreq,
  input  logic [NPORT-1:0][31:0]      radr,
  output logic [NPORT-1:0]            rvalid,
  output logic [NPORT-1:0]            hit,
  output logic [NPORT-1:0][WAYW-1:0]  hway,
  output logic [NPORT-1:0][LINEW-1:0] rdat,
  input  logic                        fill,
  input  logic                        upd,
  input  logic [31:0]                 wadr,
  input  logic [LINEW/8-1:0]          wbe,
  input  logic [LINEW-1:0]            wdat,
  input  logic                        inv,
  input  logic                        flush,
  output logic                        busy,
  output logic [WAYW-1:0]             fway
);

  localparam int unsigned IDXW = $clog2(NLINE);
  localparam int unsigned OFSW = $clog2(LINEW / 8);
  localparam int unsigned TAGW = 32 - IDXW - OFSW;

  logic [NPORT-1:0][IDXW-1:0] ridx;
  logic [NPORT-1:0][TAGW-1:0] rtag;
  logic [IDXW-1:0] widx;
  logic [TAGW-1:0] wtag;
  logic unused_ofs;

  always_comb begin
    widx       = wadr[OFSW +: IDXW];
    wtag       = wadr[31 -: TAGW];
    unused_ofs = ^wadr[OFSW-1:0];
    for (int p = 0; p < NPORT; p++) begin
      ridx[p]    = radr[p][OFSW +: IDXW];
      rtag[p]    = radr[p][31 -: TAGW];
      unused_ofs = unused_ofs ^ (^radr[p][OFSW-1:0]);
    end
  end

  logic [NWAY-1:0]                        wmatch, way_we;
  logic [NWAY-1:0][NPORT-1:0]             rmatch;
  logic [NWAY-1:0][NPORT-1:0][LINEW-1:0]  way_rdat;
  logic [LINEW/8-1:0]                     way_be;

  for (genvar w = 0; w < NWAY; w++) begin : g_way
    mpmc10_cache_way #(
      .NPORT(NPORT), .NLINE(NLINE), .LINEW(LINEW), .IDXW(IDXW), .TAGW(TAGW)
    ) u_way (
      .clk_i   (clk),
      .ridx_i  (ridx),
      .rtag_i  (rtag),
      .rmatch_o(rmatch[w]),
      .rdat_o  (way_rdat[w]),
      .widx_i  (widx),
      .wtag_i  (wtag),
      .we_i    (way_we[w]),
      .wbe_i   (way_be),
      .wdat_i  (wdat),
      .wmatch_o(wmatch[w])
    );
  end

  flush_state_e    state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [NWAY-1:0] valid_q [NLINE];
  logic [WAYW-1:0] rr_q [NLINE];
  logic [WAYW-1:0] fway_q;

  assign busy = (state_q == StFlush);
  assign fway = fway_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: if (flush) begin
        state_d = StFlush;
        idx_d   = '0;
      end
      StFlush: begin
        if (idx_q == IDXW'(NLINE - 1)) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [NWAY-1:0] wvalid, whit;
  logic            any_hit, any_free, do_fill, do_upd, do_inv;
  logic [WAYW-1:0] hit_way, free_way, victim;

  always_comb begin
    wvalid   = valid_q[widx];
    whit     = wmatch & wvalid;
    any_hit  = |whit;
    any_free = ~&wvalid;
    hit_way  = '0;
    free_way = '0;
    // Descending scan so the lowest matching index wins.
    for (int w = NWAY - 1; w >= 0; w--) begin
      if (whit[w])    hit_way  = WAYW'(w);
      if (!wvalid[w]) free_way = WAYW'(w);
    end
    victim  = any_hit ? hit_way : (any_free ? free_way : rr_q[widx]);
    do_fill = fill & ~busy;
    do_upd  = upd & ~fill & ~busy & any_hit;
    do_inv  = inv & ~fill & ~upd & ~busy & any_hit;
    way_we  = '0;
    way_be  = do_fill ? '1 : wbe;
    if (do_fill)     way_we[victim] = 1'b1;
    else if (do_upd) way_we = whit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      fway_q  <= '0;
      for (int i = 0; i < NLINE; i++) begin
        valid_q[i] <= '0;
        rr_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (busy) begin
        valid_q[idx_q] <= '0;
      end else if (do_fill) begin
        valid_q[widx][victim] <= 1'b1;
        fway_q                <= victim;
        if (!any_hit && !any_free) rr_q[widx] <= WAYW'((32'(rr_q[widx]) + 1) % NWAY);
      end else if (do_inv) begin
        valid_q[widx] <= wvalid & ~whit;
      end
    end
  end

  // Stage 1 captures valid bits alongside the way RAM reads; busy or idle ports see none.
  logic [NPORT-1:0]            req1_q;
  logic [NPORT-1:0][NWAY-1:0]  vb1_q;
  logic [NPORT-1:0]            hit_c;
  logic [NPORT-1:0][WAYW-1:0]  hway_c;
  logic [NPORT-1:0][LINEW-1:0] rdat_c;

  always_comb begin
    hit_c  = '0;
    hway_c = '0;
    rdat_c = '0;
    for (int p = 0; p < NPORT; p++) begin
      for (int w = 0; w < NWAY; w++) begin
        if (rmatch[w][p] && vb1_q[p][w]) begin
          hit_c[p]  = 1'b1;
          hway_c[p] = WAYW'(w);
          rdat_c[p] = rdat_c[p] | way_rdat[w][p];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req1_q <= '0;
      vb1_q  <= '0;
      rvalid <= '0;
      hit    <= '0;
      hway   <= '0;
      rdat   <= '0;
    end else begin
      req1_q <= rreq;
      for (int p = 0; p < NPORT; p++) begin
        vb1_q[p] <= (busy || !rreq[p]) ? '0 : valid_q[ridx[p]];
      end
      rvalid <= req1_q;
      hit    <= hit_c;
      hway   <= hway_c;
      rdat   <= rdat_c;
    end
  end

endmodule

// File: tb/tb_mpmc10_cache.sv
// Directed self-checking bench for mpmc10_cache at default parameters.
module tb_mpmc10_cache;
  import mpmc10_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rreq;
  logic [7:0][31:0]  radr;
  logic [7:0]        rvalid, hit;
  logic [7:0][1:0]   hway;
  logic [7:0][255:0] rdat;
  logic              fill, upd, inv, flush, busy;
  logic [31:0]       wadr;
  logic [31:0]       wbe;
  logic [255:0]      wdat;
  logic [1:0]        fway;

  int checks = 0;
  int failures = 0;

  mpmc10_cache u_dut (
    .clk(clk), .rst(rst), .rreq(rreq), .radr(radr), .rvalid(rvalid), .hit(hit),
    .hway(hway), .rdat(rdat), .fill(fill), .upd(upd), .wadr(wadr), .wbe(wbe),
    .wdat(wdat), .inv(inv), .flush(flush), .busy(busy), .fway(fway)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] line(input int unsigned s);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'hA5000000 + s * 32'h100 + i;
    return v;
  endfunction

  function automatic logic [31:0] adr(input int unsigned tag, input int unsigned idx);
    return (tag << 12) | (idx << 5);
  endfunction

  task automatic do_fill(input logic [31:0] a, input logic [255:0] d);
    wadr = a; wdat = d; fill = 1'b1;
    tick();
    fill = 1'b0;
  endtask

  task automatic rd(input int p, input logic [31:0] a);
    rreq = '0; rreq[p] = 1'b1; radr[p] = a;
    tick();
    rreq = '0;
    tick();
  endtask

  task automatic expect_rd(input string tag, input int p, input logic h, input logic [1:0] w,
                           input logic [255:0] d);
    chk({tag, "_rvalid"}, 256'(rvalid), 256'(8'(1) << p));
    chk({tag, "_hit"}, 256'(hit[p]), 256'(h));
    if (h) chk({tag, "_hway"}, 256'(hway[p]), 256'(w));
    chk({tag, "_rdat"}, rdat[p], h ? d : 256'd0);
  endtask

  mpmc10_cache_line_t exp_line;
  int cnt;
  int vcnt [8];

  initial begin
    rst = 1'b1; rreq = '0; radr = '0; fill = 0; upd = 0; inv = 0; flush = 0;
    wadr = '0; wbe = '0; wdat = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_rvalid", 256'(rvalid), 256'd0);
    chk("rst_hit", 256'(hit), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_fway", 256'(fway), 256'd0);
    chk("rst_rdat3", rdat[3], 256'd0);

    // Basic fill then hit / same-index miss
    do_fill(32'h0000_1000, line(1));
    chk("fill_fway", 256'(fway), 256'd0);
    rd(3, 32'h0000_1000);
    expect_rd("hitA", 3, 1'b1, 2'd0, line(1));
    tick();
    chk("rvalid_pulse", 256'(rvalid), 256'd0);
    rd(3, 32'h0000_2000);
    expect_rd("miss2000", 3, 1'b0, 2'd0, 256'd0);

    // Five fills at index 1: ways 0..3 then round-robin evicts way 0
    for (int t = 1; t <= 5; t++) begin
      do_fill(adr(t, 1), line(10 + t));
      chk($sformatf("fway_t%0d", t), 256'(fway), 256'((t - 1) % 4));
    end
    rd(0, adr(1, 1));
    expect_rd("evicted_t1", 0, 1'b0, 2'd0, 256'd0);
    rd(1, adr(5, 1));
    expect_rd("hit_t5", 1, 1'b1, 2'd0, line(15));
    do_fill(adr(3, 1), line(40));
    chk("refill_fway", 256'(fway), 256'd2);
    rd(2, adr(3, 1));
    expect_rd("refill_t3", 2, 1'b1, 2'd2, line(40));
    do_fill(adr(6, 1), line(16));
    chk("rr_next_fway", 256'(fway), 256'd1);

    // Byte-masked update on hit, then an update miss
    wadr = 32'h0000_1000; wdat = {8{32'hEEEE_EEEE}}; wbe = 32'h0000_000F; upd = 1'b1;
    tick();
    upd = 1'b0;
    exp_line.tag  = 20'h1;
    exp_line.data = line(1);
    exp_line.data[31:0] = 32'hEEEE_EEEE;
    rd(4, 32'h0000_1000);
    expect_rd("upd_hit", 4, 1'b1, 2'd0, exp_line.data);
    wadr = 32'h0000_3000; wdat = '1; wbe = '1; upd = 1'b1;
    tick();
    upd = 1'b0;
    rd(5, 32'h0000_1000);
    expect_rd("upd_miss_keep", 5, 1'b1, 2'd0, exp_line.data);
    rd(6, 32'h0000_3000);
    expect_rd("upd_miss_absent", 6, 1'b0, 2'd0, 256'd0);

    // Invalidate one line, neighbour index untouched
    wadr = 32'h0000_1000; inv = 1'b1;
    tick();
    inv = 1'b0;
    rd(7, 32'h0000_1000);
    expect_rd("inv_miss", 7, 1'b0, 2'd0, 256'd0);
    rd(7, adr(5, 1));
    expect_rd("inv_other", 7, 1'b1, 2'd0, line(15));

    // Same-cycle fill and read: read-first miss, then hit
    wadr = 32'h0000_4000; wdat = line(50); fill = 1'b1;
    rreq = 8'h01; radr[0] = 32'h0000_4000;
    tick();
    fill = 1'b0;
    tick();
    expect_rd("rf_miss", 0, 1'b0, 2'd0, 256'd0);
    rreq = '0;
    tick();
    expect_rd("rf_hit", 0, 1'b1, 2'd0, line(50));

    // All ports streaming for 100 cycles
    for (int p = 0; p < 8; p++) do_fill(adr(7, 10 + p), line(100 + p));
    for (int p = 0; p < 8; p++) begin
      radr[p] = adr(7, 10 + p);
      vcnt[p] = 0;
    end
    for (int c = 0; c < 102; c++) begin
      rreq = (c < 100) ? 8'hFF : 8'h00;
      tick();
      for (int p = 0; p < 8; p++) begin
        if (rvalid[p]) begin
          vcnt[p]++;
          chk($sformatf("bulk_hit_p%0d", p), 256'(hit[p]), 256'd1);
          chk($sformatf("bulk_dat_p%0d", p), rdat[p], line(100 + p));
        end
      end
    end
    for (int p = 0; p < 8; p++) chk($sformatf("bulk_cnt_p%0d", p), 256'(vcnt[p]), 256'd100);

    // Flush: second flush and a fill while busy are ignored; busy reads miss
    flush = 1'b1;
    tick();
    cnt = busy ? 1 : 0;
    chk("flush_busy", 256'(busy), 256'd1);
    wadr = 32'h0000_5000; wdat = line(60); fill = 1'b1;
    rreq = 8'h01; radr[0] = adr(7, 10);
    tick();
    if (busy) cnt++;
    flush = 1'b0; fill = 1'b0; rreq = '0;
    tick();
    if (busy) cnt++;
    expect_rd("busy_read", 0, 1'b0, 2'd0, 256'd0);
    for (int g = 0; g < 300 && busy; g++) begin
      tick();
      if (busy) cnt++;
    end
    chk("flush_len", 256'(cnt), 256'd128);
    radr[0] = 32'h0000_5000; radr[1] = 32'h0000_4000;
    radr[2] = adr(7, 10);    radr[3] = adr(5, 1);
    rreq = 8'h0F;
    tick();
    rreq = '0;
    tick();
    chk("post_flush_rvalid", 256'(rvalid), 256'h0F);
    chk("post_flush_hit", 256'(hit), 256'd0);
    chk("post_flush_rdat2", rdat[2], 256'd0);

    // Reset in the middle of a flush
    do_fill(32'h0000_1000, line(1));
    do_fill(32'h0000_2000, line(2));
    chk("pre_rst_fway", 256'(fway), 256'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cnt = 1;
    while (cnt < 40) begin
      tick();
      cnt++;
    end
    chk("mid_flush_busy", 256'(busy), 256'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_abort_busy", 256'(busy), 256'd0);
    chk("rst_abort_fway", 256'(fway), 256'd0);
    tick();
    rst = 1'b0;
    tick();
    radr[0] = 32'h0000_1000; radr[1] = 32'h0000_2000;
    rreq = 8'h03;
    tick();
    rreq = '0;
    tick();
    chk("rst_empty_rvalid", 256'(rvalid), 256'h03);
    chk("rst_empty_hit", 256'(hit), 256'd0);
    chk("rst_idle_busy", 256'(busy), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
